// File: rtl/rv64_pkg.sv
// Shared rename-stage sizing: lane count, register index widths and free-list geometry.
package rv64_pkg;
  localparam int unsigned DECODE_NUM = 4;
  localparam int unsigned AREG       = 5;
  localparam int unsigned PREG       = 6;
  localparam int unsigned FL_DEPTH   = 2**PREG - 2**AREG;
  localparam int unsigned FL_PTR_W   = $clog2(FL_DEPTH) + 1;

  typedef logic [PREG-1:0] preg_t;
endpackage

// File: rtl/lane_prefix_cnt.sv
// Per-lane exclusive prefix popcount of a lane mask, plus the total set-bit count.
module lane_prefix_cnt #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = $clog2(N) + 1
) (
  input  logic [N-1:0]  mask_i,
  output logic [CW-1:0] pre_o [N],
  output logic [CW-1:0] total_o
);
  logic [CW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pre_o[i] = acc;
      acc      = acc + CW'(mask_i[i]);
    end
    total_o = acc;
  end
endmodule

// File: rtl/free_list.sv
// Physical-register free list: multi-lane allocate/release with a committed head
// pointer so a flush restores every speculatively allocated preg in one cycle.
module free_list #(
  parameter int unsigned DECODE_NUM = rv64_pkg::DECODE_NUM,
  parameter int unsigned AREG       = rv64_pkg::AREG,
  parameter int unsigned PREG       = rv64_pkg::PREG,
  parameter int unsigned DEPTH      = 2**PREG - 2**AREG
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DECODE_NUM-1:0]      alloc_req,
  output logic                       alloc_ready,
  output logic [DECODE_NUM*PREG-1:0] alloc_preg,
  input  logic [DECODE_NUM-1:0]      rel_valid,
  input  logic [DECODE_NUM*PREG-1:0] rel_preg,
  input  logic [DECODE_NUM-1:0]      commit_alloc,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     free_cnt
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CW    = $clog2(DECODE_NUM) + 1;

  logic [PREG-1:0]  fl_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, chead_q, chead_d;

  logic [CW-1:0]    req_pre [DECODE_NUM];
  logic [CW-1:0]    rel_pre [DECODE_NUM];
  logic [CW-1:0]    cmt_pre [DECODE_NUM];
  logic [CW-1:0]    req_tot, rel_tot, cmt_tot;
  logic [IDX_W-1:0] rd_idx [DECODE_NUM];
  logic [IDX_W-1:0] wr_idx [DECODE_NUM];
  logic             fire;

  lane_prefix_cnt #(.N(DECODE_NUM), .CW(CW)) u_req_cnt (
    .mask_i (alloc_req), .pre_o (req_pre), .total_o (req_tot)
  );
  lane_prefix_cnt #(.N(DECODE_NUM), .CW(CW)) u_rel_cnt (
    .mask_i (rel_valid), .pre_o (rel_pre), .total_o (rel_tot)
  );
  lane_prefix_cnt #(.N(DECODE_NUM), .CW(CW)) u_cmt_cnt (
    .mask_i (commit_alloc), .pre_o (cmt_pre), .total_o (cmt_tot)
  );

  always_comb begin
    alloc_preg  = '0;
    free_cnt    = tail_q - head_q;
    alloc_ready = !flush && (free_cnt >= PTR_W'(req_tot));
    fire        = alloc_ready && (|alloc_req);
    for (int unsigned i = 0; i < DECODE_NUM; i++) begin
      rd_idx[i] = IDX_W'(head_q + PTR_W'(req_pre[i]));
      wr_idx[i] = IDX_W'(tail_q + PTR_W'(rel_pre[i]));
      alloc_preg[i*PREG +: PREG] = fl_q[rd_idx[i]];
    end

    // Flush rewinds to the committed head, including commits landing this same cycle.
    head_d = head_q;
    if (flush)
      head_d = chead_q + PTR_W'(cmt_tot);
    else if (fire)
      head_d = head_q + PTR_W'(req_tot);

    tail_d  = tail_q + PTR_W'(rel_tot);
    chead_d = chead_q + PTR_W'(cmt_tot);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= {1'b1, {IDX_W{1'b0}}};
      for (int unsigned i = 0; i < DEPTH; i++)
        fl_q[i] <= PREG'(2**AREG + i);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      chead_q <= chead_d;
      for (int unsigned i = 0; i < DECODE_NUM; i++)
        if (rel_valid[i])
          fl_q[wr_idx[i]] <= rel_preg[i*PREG +: PREG];
    end
  end

  logic [PTR_W:0] cnt_after_rel;
  logic           rel_x0;

  always_comb begin
    cnt_after_rel = {1'b0, free_cnt} + (PTR_W+1)'(rel_tot);
    rel_x0        = 1'b0;
    for (int unsigned i = 0; i < DECODE_NUM; i++)
      if (rel_valid[i] && (rel_preg[i*PREG +: PREG] == '0))
        rel_x0 = 1'b1;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    cnt_after_rel <= (PTR_W+1)'(DEPTH));
  a_chead_behind_head: assert property (@(posedge clk) disable iff (rst)
    (PTR_W'(head_q - chead_q)) >= PTR_W'(cmt_tot));
  a_no_x0_release: assert property (@(posedge clk) disable iff (rst) !rel_x0);
endmodule
